// File: rtl/alu_op_dispatcher.sv
// alu_op_dispatcher: front-end for the 16-bit ALU control unit.
// Buffers requests in a small FIFO, issues one operation at a time as a
// start pulse with a stable opcode and operands, waits for finish (bounded
// by a timeout) and returns the captured result over a valid/ready channel.
module alu_op_dispatcher #(
  parameter int DW      = 16,
  parameter int OPW     = 4,
  parameter int TAGW    = 2,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OPW-1:0]  req_op,
  input  logic [DW-1:0]   req_x,
  input  logic [DW-1:0]   req_y,
  input  logic [TAGW-1:0] req_tag,
  output logic [OPW-1:0]  cu_s,
  output logic            cu_start,
  input  logic            cu_finish,
  output logic [DW-1:0]   op_x,
  output logic [DW-1:0]   op_y,
  input  logic [DW-1:0]   dp_hi,
  input  logic [DW-1:0]   dp_lo,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [TAGW-1:0] rsp_tag,
  output logic [DW-1:0]   rsp_hi,
  output logic [DW-1:0]   rsp_lo,
  output logic            rsp_timeout,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]    FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0]  LAST_CNT  = CW'(TIMEOUT - 1);
  localparam logic [OPW-1:0] NOP_OP    = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [DW-1:0]   x;
    logic [DW-1:0]   y;
    logic [TAGW-1:0] tag;
  } req_t;

  state_t          state;
  req_t            mem [DEPTH];
  req_t            head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   cnt;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [OPW-1:0]  op_r;
  logic [DW-1:0]   x_r;
  logic [DW-1:0]   y_r;
  logic [TAGW-1:0] tag_r;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign head      = mem[rd_ptr];

  assign cu_s    = op_r;
  assign op_x    = x_r;
  assign op_y    = y_r;
  assign rsp_tag = tag_r;
  assign busy    = (state != IDLE) || !empty;

  // Request storage write port.
  // NOTE: the storage array is not reset; entries are only read when count
  // says they are valid, so flushing the pointers and count is sufficient.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: req_op, x: req_x, y: req_y, tag: req_tag};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // in the design updates from values sampled before the same clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue FSM with registered start pulse, operand holding and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_r        <= '0;
      x_r         <= '0;
      y_r         <= '0;
      tag_r       <= '0;
      cu_start    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_hi      <= '0;
      rsp_lo      <= '0;
      rsp_timeout <= 1'b0;
      cnt         <= '0;
    end else begin
      cu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            op_r  <= head.op;
            x_r   <= head.x;
            y_r   <= head.y;
            tag_r <= head.tag;
            if (head.op == NOP_OP) begin
              // NOP completes immediately without touching the control unit.
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_hi      <= '0;
              rsp_lo      <= '0;
              rsp_timeout <= 1'b0;
            end else begin
              state    <= ISSUE;
              cu_start <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // finish is deliberately ignored here; a level left high from a
          // previous op must not complete this one before WAIT.
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cu_finish) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_hi      <= dp_hi;
            rsp_lo      <= dp_lo;
            rsp_timeout <= 1'b0;
          end else if (cnt == LAST_CNT) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_hi      <= '0;
            rsp_lo      <= '0;
            rsp_timeout <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cnt       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Self-checking bench for alu_op_dispatcher: a table of single-op vectors
// plus hand-written sequences for backpressure, FIFO full and reset.
module tb_alu_op_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [1:0]  req_tag;
  logic [3:0]  cu_s;
  logic        cu_start;
  logic        cu_finish;
  logic [15:0] op_x;
  logic [15:0] op_y;
  logic [15:0] dp_hi;
  logic [15:0] dp_lo;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_tag;
  logic [15:0] rsp_hi;
  logic [15:0] rsp_lo;
  logic        rsp_timeout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_dispatcher dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
    .cu_s(cu_s), .cu_start(cu_start), .cu_finish(cu_finish),
    .op_x(op_x), .op_y(op_y), .dp_hi(dp_hi), .dp_lo(dp_lo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  tag;
    int          fin_dly;   // WAIT cycles before finish; -1 means never
    logic [15:0] dp_hi;
    logic [15:0] dp_lo;
    logic [15:0] exp_hi;
    logic [15:0] exp_lo;
    logic        exp_to;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [15:0] x,
                           input logic [15:0] y, input logic [1:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    req_tag   = tag;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 8 && cu_start !== 1'b1; i++) tick();
    check("start_seen", 32'(cu_start), 32'd1);
  endtask

  // From WAIT: finish with the given result, check the response, release it.
  task automatic finish_op(input logic [1:0] exp_tag, input logic [15:0] hi, input logic [15:0] lo);
    cu_finish = 1'b1;
    dp_hi     = hi;
    dp_lo     = lo;
    tick();
    cu_finish = 1'b0;
    check("seq_rsp_valid", 32'(rsp_valid), 32'd1);
    check("seq_rsp_tag",   32'(rsp_tag),   32'(exp_tag));
    check("seq_rsp_hi",    32'(rsp_hi),    32'(hi));
    check("seq_rsp_lo",    32'(rsp_lo),    32'(lo));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic issue_and_finish(input logic [1:0] exp_tag, input logic [15:0] hi, input logic [15:0] lo);
    wait_start();
    tick();
    finish_op(exp_tag, hi, lo);
  endtask

  task automatic run_vector(input vec_t v);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    drive_req(v.op, v.x, v.y, v.tag);
    tick();
    req_valid = 1'b0;
    check("busy_queued", 32'(busy), 32'd1);
    tick();
    if (v.op == 4'b1111) begin
      check("nop_no_start", 32'(cu_start),  32'd0);
      check("nop_rsp_valid", 32'(rsp_valid), 32'd1);
    end else begin
      check("start_pulse", 32'(cu_start), 32'd1);
      check("cu_s",        32'(cu_s),     32'(v.op));
      check("op_x",        32'(op_x),     32'(v.x));
      check("op_y",        32'(op_y),     32'(v.y));
      tick();
      check("start_one_cycle", 32'(cu_start), 32'd0);
      dp_hi = v.dp_hi;
      dp_lo = v.dp_lo;
      if (v.fin_dly < 0) begin
        repeat (63) tick();
        check("no_rsp_before_timeout", 32'(rsp_valid), 32'd0);
        tick();
        check("timeout_rsp_valid", 32'(rsp_valid), 32'd1);
      end else begin
        repeat (v.fin_dly) tick();
        check("no_rsp_before_finish", 32'(rsp_valid), 32'd0);
        cu_finish = 1'b1;
        tick();
        cu_finish = 1'b0;
        check("finish_rsp_valid", 32'(rsp_valid), 32'd1);
      end
    end
    check("rsp_tag",     32'(rsp_tag),     32'(v.tag));
    check("rsp_hi",      32'(rsp_hi),      32'(v.exp_hi));
    check("rsp_lo",      32'(rsp_lo),      32'(v.exp_lo));
    check("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_to));
    check("no_start_in_resp", 32'(cu_start), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("idle_not_busy",  32'(busy),      32'd0);
  endtask

  initial begin
    vecs[0] = '{op: 4'b0000, x: 16'h0003, y: 16'h0005, tag: 2'd1, fin_dly: 9,
                dp_hi: 16'h0000, dp_lo: 16'h000F, exp_hi: 16'h0000, exp_lo: 16'h000F, exp_to: 1'b0};
    vecs[1] = '{op: 4'b0011, x: 16'h1234, y: 16'h0002, tag: 2'd2, fin_dly: 0,
                dp_hi: 16'hABCD, dp_lo: 16'h1234, exp_hi: 16'hABCD, exp_lo: 16'h1234, exp_to: 1'b0};
    vecs[2] = '{op: 4'b0101, x: 16'hFFFF, y: 16'h0001, tag: 2'd3, fin_dly: -1,
                dp_hi: 16'hDEAD, dp_lo: 16'hBEEF, exp_hi: 16'h0000, exp_lo: 16'h0000, exp_to: 1'b1};
    vecs[3] = '{op: 4'b0110, x: 16'h8000, y: 16'h7FFF, tag: 2'd0, fin_dly: 63,
                dp_hi: 16'h5555, dp_lo: 16'hAAAA, exp_hi: 16'h5555, exp_lo: 16'hAAAA, exp_to: 1'b0};
    vecs[4] = '{op: 4'b1111, x: 16'h4444, y: 16'h3333, tag: 2'd1, fin_dly: 0,
                dp_hi: 16'h7777, dp_lo: 16'h8888, exp_hi: 16'h0000, exp_lo: 16'h0000, exp_to: 1'b0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_x     = '0;
    req_y     = '0;
    req_tag   = '0;
    cu_finish = 1'b0;
    dp_hi     = '0;
    dp_lo     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst_req_ready",   32'(req_ready),   32'd1);
    check("rst_cu_start",    32'(cu_start),    32'd0);
    check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_cu_s",        32'(cu_s),        32'd0);
    check("rst_op_x",        32'(op_x),        32'd0);
    check("rst_op_y",        32'(op_y),        32'd0);
    check("rst_rsp_tag",     32'(rsp_tag),     32'd0);
    check("rst_rsp_hi",      32'(rsp_hi),      32'd0);
    check("rst_rsp_lo",      32'(rsp_lo),      32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);

    // Table-driven single operations.
    for (int i = 0; i < 5; i++) run_vector(vecs[i]);

    // Response backpressure with a second op queued behind it.
    drive_req(4'b0001, 16'h0101, 16'h0202, 2'd2);
    tick();
    drive_req(4'b0010, 16'h0303, 16'h0404, 2'd3);
    tick();
    req_valid = 1'b0;
    check("bp_first_start", 32'(cu_start), 32'd1);
    tick();
    cu_finish = 1'b1;
    dp_hi     = 16'h1111;
    dp_lo     = 16'h2222;
    tick();
    cu_finish = 1'b0;
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      dp_hi = 16'h9000 + 16'(i);
      dp_lo = 16'h6000 + 16'(i);
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_hi",    32'(rsp_hi),    32'h1111);
      check("bp_hold_lo",    32'(rsp_lo),    32'h2222);
      check("bp_hold_tag",   32'(rsp_tag),   32'd2);
      check("bp_no_start",   32'(cu_start),  32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle_gap_valid", 32'(rsp_valid), 32'd0);
    check("bp_idle_gap_start", 32'(cu_start),  32'd0);
    tick();
    check("bp_next_start", 32'(cu_start), 32'd1);
    check("bp_next_cu_s",  32'(cu_s),     32'd2);
    check("bp_next_op_x",  32'(op_x),     32'h0303);
    tick();
    finish_op(2'd3, 16'h0033, 16'h0044);

    // FIFO full: one op in flight, two buffered, a third stalls until a pop.
    drive_req(4'b0100, 16'h0010, 16'h0020, 2'd3);
    tick();
    req_valid = 1'b0;
    wait_start();
    tick();
    drive_req(4'b0100, 16'h0011, 16'h0021, 2'd0);
    tick();
    drive_req(4'b0100, 16'h0012, 16'h0022, 2'd1);
    tick();
    drive_req(4'b0100, 16'h0013, 16'h0023, 2'd2);
    check("full_ready_low", 32'(req_ready), 32'd0);
    repeat (3) tick();
    check("full_ready_still_low", 32'(req_ready), 32'd0);
    cu_finish = 1'b1;
    dp_hi     = 16'h0000;
    dp_lo     = 16'h0C03;
    tick();
    cu_finish = 1'b0;
    check("full_first_tag", 32'(rsp_tag), 32'd3);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("full_ready_before_pop", 32'(req_ready), 32'd0);
    tick();
    check("ready_after_pop", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    finish_op(2'd0, 16'h0000, 16'h0C00);
    issue_and_finish(2'd1, 16'h0000, 16'h0C01);
    issue_and_finish(2'd2, 16'h0000, 16'h0C02);
    check("full_drained", 32'(busy), 32'd0);

    // Reset during WAIT with one request queued.
    drive_req(4'b0001, 16'h00AA, 16'h00BB, 2'd1);
    tick();
    req_valid = 1'b0;
    wait_start();
    tick();
    drive_req(4'b0010, 16'h00CC, 16'h00DD, 2'd2);
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cu_start",  32'(cu_start),  32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_busy",      32'(busy),      32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flushed_no_start", 32'(cu_start),  32'd0);
      check("flushed_no_rsp",   32'(rsp_valid), 32'd0);
    end
    run_vector('{op: 4'b1111, x: 16'h0000, y: 16'h0000, tag: 2'd2, fin_dly: 0,
                 dp_hi: 16'h1234, dp_lo: 16'h5678, exp_hi: 16'h0000, exp_lo: 16'h0000, exp_to: 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_dispatcher.md
Name: alu_op_dispatcher

Overview:
- Upstream front-end for the 16-bit ALU Control_Unit.
- Accepts operation requests (opcode, two operands, tag) over a valid/ready handshake and buffers them in a small FIFO.
- Issues each operation to the control unit as a one-cycle start pulse with a stable opcode on s, then waits for finish, captures the datapath result, and returns it over a valid/ready response channel.
- Guards against a hung control unit with a timeout.

Parameters:
- DW, 16, operand/result half width
- OPW, 4, opcode width (matches control unit s)
- TAGW, 2, request tag width
- DEPTH, 2, request FIFO depth (power of two, >=2)
- TIMEOUT, 64, max cycles in WAIT before forced completion

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  FIFO not full
- req_op  input  OPW  opcode
- req_x  input  DW  operand X
- req_y  input  DW  operand Y
- req_tag  input  TAGW  request tag
- cu_s  output  OPW  opcode to control unit s
- cu_start  output  1  start pulse to control unit
- cu_finish  input  1  finish from control unit
- op_x  output  DW  operand X to datapath, stable ISSUE..WAIT
- op_y  output  DW  operand Y to datapath, stable ISSUE..WAIT
- dp_hi  input  DW  datapath result high word (A)
- dp_lo  input  DW  datapath result low word (Q)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_tag  output  TAGW  tag of completed op
- rsp_hi  output  DW  result high word
- rsp_lo  output  DW  result low word
- rsp_timeout  output  1  op ended by timeout
- busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, FIFO empty, timeout counter=0.
  - All outputs 0 except req_ready=1.
  - Reset mid-operation flushes FIFO and abandons in-flight op; no response is produced for it.
- FIFO:
  - Push when req_valid && req_ready; req_ready = !full, combinational from occupancy only.
  - Pop only on the IDLE->ISSUE transition.
  - Push and pop in the same cycle are both legal; occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop head into op registers (op, x, y, tag) and go to ISSUE, else stay. Opcode 4'b1111 is NOP: pop, then go directly to RESP with rsp_hi=rsp_lo=0, rsp_timeout=0, no cu_start.
  - ISSUE: cu_start=1 for exactly this one cycle; next state WAIT. cu_finish is ignored in ISSUE.
  - WAIT:
    - Counter increments each cycle.
    - If cu_finish=1: capture dp_hi/dp_lo into rsp_hi/rsp_lo, rsp_timeout=0, go to RESP.
    - Else if counter == TIMEOUT-1: rsp_hi=rsp_lo=0, rsp_timeout=1, go to RESP.
    - Finish wins over timeout in the same cycle.
  - RESP: rsp_valid=1. Hold rsp_tag, rsp_hi, rsp_lo and rsp_timeout stable until rsp_ready=1, then rsp_valid drops next cycle, counter clears, and the FSM goes to IDLE.
- cu_s, op_x and op_y:
  - Driven from op registers, constant from ISSUE entry until RESP exit.
  - 0 in IDLE after reset; hold last value otherwise.
- Latency: request accepted at edge k into empty FIFO with FSM idle → cu_start high in the cycle after edge k+1. The earliest rsp_valid is 1 cycle after the edge sampling cu_finish. Back-to-back ops incur 1 IDLE cycle between RESP and the next ISSUE.
- Only one op is in flight; the FIFO continues accepting requests during ISSUE/WAIT/RESP.
- cu_finish level held high by the control unit is sampled once; re-entry into WAIT waits for a fresh ISSUE.

Test Plan:
- Reset then single request op=0000, x=16'h0003, y=16'h0005, tag=1 → cu_s=0000 with cu_start high exactly 1 cycle; drive cu_finish 10 cycles later with dp_hi=0, dp_lo=16'h000F → rsp_valid, rsp_tag=1, rsp_lo=16'h000F, rsp_timeout=0.
- Three requests back-to-back with DEPTH=2 while the first op is in WAIT → req_ready drops after 2 buffered; the third is accepted after the first pop; responses return tags in order 0,1,2.
- Never assert cu_finish, TIMEOUT=64 → rsp_valid exactly 64 cycles after entering WAIT, rsp_timeout=1, rsp_hi=rsp_lo=0.
- cu_finish asserted on the same cycle the counter hits TIMEOUT-1 → rsp_timeout=0 and the captured result is returned.
- Hold rsp_ready=0 for 5 cycles in RESP while changing dp_hi/dp_lo → rsp fields unchanged, rsp_valid stays high, no new cu_start; release → next op issues after 1 IDLE cycle.
- Assert rst during WAIT with 1 queued request → next cycle state IDLE, FIFO empty, cu_start=0, rsp_valid=0, req_ready=1; a NOP (op=1111) afterwards gives rsp_valid with no cu_start.
